mode_select: RTL and testbench

Debounces the board's user push-button, turns short presses into a wrapping 3-bit run mode and long presses into a return to mode 0, and drives the NIOS system's `pio_mode_export[2:0]` input. It sits directly upstream of the NIOS subsystem in the top level, between the raw button pin and the PIO. Software polls the PIO to select the memory-test pattern.

---
 rtl/mode_select_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/mode_select.sv | 105 ++++++++++
 tb/tb_mode_select.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mode_select_pkg.sv
// Shared types and board constants for the push-button mode selector.
// Default cycle counts assume the 12 MHz board clock.
package mode_select_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } mode_state_t;

   localparam int MODE_W              = 3;
   localparam int CLK_HZ              = 12_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = 120_000;
   localparam int LONG_CYCLES_DEF     = 12_000_000;

   // Counter width for a count of n cycles; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, polarity normalisation and stable-level debounce.
// btn_db is 1 while the button is accepted as pressed; btn_rise marks the edge that sets it.
module btn_debounce
   import mode_select_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_db,
   output logic btn_rise
);

   localparam int             DB_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic           PIN_REL = BTN_ACTIVE_LOW;

   logic            sync_p0;
   logic            sync_p1;
   logic            pressed_p1;
   logic [DB_W-1:0] db_cnt;
   logic            db_hit;

   // Stage p0/p1: metastability synchroniser, reset to the released pin level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= PIN_REL;
         sync_p1 <= PIN_REL;
      end else begin
         sync_p0 <= btn_in;
         sync_p1 <= sync_p0;
      end
   end

   assign pressed_p1 = sync_p1 ^ BTN_ACTIVE_LOW;
   assign db_hit     = (pressed_p1 != btn_db) && (db_cnt == DB_LAST);
   assign btn_rise   = db_hit & ~btn_db;

   // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
         btn_db <= 1'b0;
      end else if (pressed_p1 == btn_db) begin
         db_cnt <= '0;
      end else if (db_hit) begin
         db_cnt <= '0;
         btn_db <= ~btn_db;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mode_select.sv
// Push-button run-mode selector feeding the NIOS mode PIO: short presses step a
// wrapping mode counter, a long press returns the mode to 0.
module mode_select
   import mode_select_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
   parameter int MODE_MAX        = 7,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic              clk_in_clk,
   input  logic              reset_reset,
   input  logic              btn_in,
   output logic [MODE_W-1:0] mode_export,
   output logic              mode_stb,
   output logic              long_press_stb
);

   localparam int               HOLD_W    = cnt_width(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [MODE_W-1:0] MODE_TOP  = MODE_W'(MODE_MAX);

   mode_state_t       state;
   mode_state_t       state_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              btn_db;
   logic              btn_rise;
   logic              short_hit;
   logic              long_hit;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
   ) u_db (
      .clk      (clk_in_clk),
      .rst      (reset_reset),
      .btn_in   (btn_in),
      .btn_db   (btn_db),
      .btn_rise (btn_rise)
   );

   always_ff @(posedge clk_in_clk) begin
      if (reset_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Entering PRESSED on the debounce edge itself makes the long-press strobe land
   // exactly LONG_CYCLES after btn_db rises.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (btn_rise) state_nxt = PRESSED;
         end
         PRESSED: begin
            if (!btn_db)                    state_nxt = btn_rise ? PRESSED : IDLE;
            else if (hold_cnt == HOLD_LAST) state_nxt = LONG_HELD;
         end
         LONG_HELD: begin
            if (!btn_db) state_nxt = btn_rise ? PRESSED : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      short_hit = 1'b0;
      long_hit  = 1'b0;
      if (state == PRESSED) begin
         short_hit = !btn_db;
         long_hit  = btn_db && (hold_cnt == HOLD_LAST);
      end
   end

   // Hold counter runs only while PRESSED and clears on every exit, so it never wraps
   always_ff @(posedge clk_in_clk) begin
      if (reset_reset) begin
         hold_cnt <= '0;
      end else if ((state == PRESSED) && !short_hit && !long_hit) begin
         hold_cnt <= hold_cnt + 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end

   always_ff @(posedge clk_in_clk) begin
      if (reset_reset) begin
         mode_export    <= '0;
         mode_stb       <= 1'b0;
         long_press_stb <= 1'b0;
      end else begin
         mode_stb       <= short_hit;
         long_press_stb <= long_hit;
         if (long_hit) begin
            mode_export <= '0;
         end else if (short_hit) begin
            mode_export <= (mode_export == MODE_TOP) ? '0 : mode_export + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mode_select.sv
// Directed bench for mode_select with short debounce/long-press counts.
// dut uses MODE_MAX=7, dut2 uses MODE_MAX=2; both share clock and reset.
module tb_mode_select;
   import mode_select_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic       btn2;
   logic [2:0] mode;
   logic       mode_stb;
   logic       long_stb;
   logic [2:0] mode2;
   logic       mode_stb2;
   logic       long_stb2;

   int checks   = 0;
   int errors   = 0;
   int stb_cnt  = 0;
   int long_cnt = 0;
   int both_cnt = 0;
   int base_stb;
   int base_long;

   always #5 clk = ~clk;

   mode_select #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (20),
      .MODE_MAX        (7),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk_in_clk     (clk),
      .reset_reset    (rst),
      .btn_in         (btn),
      .mode_export    (mode),
      .mode_stb       (mode_stb),
      .long_press_stb (long_stb)
   );

   mode_select #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (20),
      .MODE_MAX        (2),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut2 (
      .clk_in_clk     (clk),
      .reset_reset    (rst),
      .btn_in         (btn2),
      .mode_export    (mode2),
      .mode_stb       (mode_stb2),
      .long_press_stb (long_stb2)
   );

   always @(posedge clk) begin
      if (mode_stb) stb_cnt++;
      if (long_stb) long_cnt++;
      if (mode_stb && long_stb) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int which, input logic v);
      if (which == 0) btn = v;
      else            btn2 = v;
   endtask

   function automatic logic [2:0] get_mode(input int which);
      return (which == 0) ? mode : mode2;
   endfunction

   function automatic logic get_stb(input int which);
      return (which == 0) ? mode_stb : mode_stb2;
   endfunction

   // 8-cycle press starting at a negedge; the strobe is visible 15 negedges later.
   task automatic short_press(input int which, input logic [2:0] old_m, input logic [2:0] new_m);
      set_btn(which, 1'b0);
      step(8);
      set_btn(which, 1'b1);
      step(6);
      check("pre_stb", get_stb(which), 1'b0);
      check("pre_mode", get_mode(which), old_m);
      step(1);
      check("stb", get_stb(which), 1'b1);
      check("mode", get_mode(which), new_m);
      step(1);
      check("post_stb", get_stb(which), 1'b0);
      step(4);
   endtask

   initial begin
      rst  = 1'b1;
      btn  = 1'b0;
      btn2 = 1'b1;

      // Reset with the button held down
      step(2);
      check("rst_mode", mode, 3'd0);
      check("rst_stb", mode_stb, 1'b0);
      check("rst_long", long_stb, 1'b0);
      step(1);
      check("rst_mode2", mode2, 3'd0);
      rst = 1'b0;
      step(5);
      check("rst_db_early", dut.u_db.btn_db, 1'b0);
      step(1);
      check("rst_db_rise", dut.u_db.btn_db, 1'b1);
      step(2);
      btn = 1'b1;
      step(6);
      check("rst_press_pre", mode, 3'd0);
      step(1);
      check("rst_press_stb", mode_stb, 1'b1);
      check("rst_press_mode", mode, 3'd1);
      step(5);

      // Glitch rejection from a clean reset
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      check("glitch_start_mode", mode, 3'd0);
      base_stb  = stb_cnt;
      base_long = long_cnt;
      btn = 1'b0;
      step(3);
      btn = 1'b1;
      step(3);
      check("glitch_db", dut.u_db.btn_db, 1'b0);
      step(3);
      check("glitch_db_late", dut.u_db.btn_db, 1'b0);
      step(14);
      check("glitch_mode", mode, 3'd0);
      check("glitch_stbs", stb_cnt - base_stb, 0);
      check("glitch_longs", long_cnt - base_long, 0);

      // Eight short presses wrap 1..7,0
      base_stb = stb_cnt;
      for (int i = 0; i < 8; i++) begin
         short_press(0, 3'(i), 3'((i + 1) % 8));
      end
      check("wrap_stb_count", stb_cnt - base_stb, 8);

      // Long press from mode 5
      for (int i = 0; i < 5; i++) begin
         short_press(0, 3'(i), 3'(i + 1));
      end
      base_stb  = stb_cnt;
      base_long = long_cnt;
      btn = 1'b0;
      step(25);
      check("long_pre", long_stb, 1'b0);
      check("long_pre_mode", mode, 3'd5);
      step(1);
      check("long_stb", long_stb, 1'b1);
      check("long_mode", mode, 3'd0);
      check("long_no_short", mode_stb, 1'b0);
      step(1);
      check("long_post", long_stb, 1'b0);
      step(3);
      btn = 1'b1;
      step(15);
      check("long_rel_mode", mode, 3'd0);
      check("long_rel_stbs", stb_cnt - base_stb, 0);
      check("long_count", long_cnt - base_long, 1);

      // MODE_MAX=2 instance
      short_press(1, 3'd0, 3'd1);
      short_press(1, 3'd1, 3'd2);
      short_press(1, 3'd2, 3'd0);

      // Reset in the middle of a held press
      short_press(0, 3'd0, 3'd1);
      base_long = long_cnt;
      btn = 1'b0;
      step(16);
      check("mid_hold_cnt", dut.hold_cnt, 10);
      rst = 1'b1;
      step(1);
      check("mid_rst_mode", mode, 3'd0);
      step(1);
      check("mid_state", 32'(dut.state), 32'(IDLE));
      check("mid_db", dut.u_db.btn_db, 1'b0);
      rst = 1'b0;
      step(25);
      check("mid_long_pre", long_stb, 1'b0);
      step(1);
      check("mid_long_stb", long_stb, 1'b1);
      check("mid_long_mode", mode, 3'd0);
      btn = 1'b1;
      step(15);
      check("mid_long_count", long_cnt - base_long, 1);
      check("strobes_exclusive", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
